// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_if
//  Description : Issue/writeback/flush bundle between the pipeline and the
//                register-file hazard scoreboard.
//  Revision    : 1.0
// ============================================================================
interface regfile_scoreboard_if;
    logic       issue_valid;
    logic [3:0] issue_srcA;
    logic [3:0] issue_srcB;
    logic [3:0] issue_dstE;
    logic [3:0] issue_dstM;
    logic       issue_ready;
    logic       wb_valid;
    logic [3:0] wb_dstE;
    logic [3:0] wb_dstM;
    logic       flush;

    modport master (
        output issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
        output wb_valid, wb_dstE, wb_dstM, flush,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
        input  wb_valid, wb_dstE, wb_dstM, flush,
        output issue_ready
    );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register pending-write counters that stall issue on RAW
//                hazards or counter saturation, plus stall statistics.
//  Revision    : 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int         NREG   = 15,
    parameter int         CNT_W  = 2,
    parameter int         STAT_W = 16,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  wire                     clk,
    input  wire                     res_n,
    regfile_scoreboard_if.slave     bus,
    output logic [NREG-1:0]         busy_vec,
    output logic [STAT_W-1:0]       stall_cycles,
    output logic                    err
);

    logic [NREG-1:0]   w_busy;
    logic [NREG-1:0]   w_full;
    logic [NREG-1:0]   w_src_hit;
    logic [NREG-1:0]   w_dst_hit;
    logic [NREG-1:0]   w_wb_hit;
    logic [NREG-1:0]   w_underflow;
    logic              w_accept;
    logic [STAT_W-1:0] r_stall;
    logic              r_err;

    // Readiness looks only at registered counters, so a same-cycle writeback
    // cannot release a stall.
    assign bus.issue_ready = ~bus.flush & ~|(w_src_hit & w_busy) & ~|(w_dst_hit & w_full);
    assign w_accept        = bus.issue_valid & bus.issue_ready;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        localparam logic [3:0] c_id = 4'(i);
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        // Matching on the ID makes dstE == dstM count as a single write.
        assign w_src_hit[i] = ((bus.issue_srcA != RNONE) && (bus.issue_srcA == c_id)) ||
                              ((bus.issue_srcB != RNONE) && (bus.issue_srcB == c_id));
        assign w_dst_hit[i] = ((bus.issue_dstE != RNONE) && (bus.issue_dstE == c_id)) ||
                              ((bus.issue_dstM != RNONE) && (bus.issue_dstM == c_id));
        assign w_wb_hit[i]  = ((bus.wb_dstE != RNONE) && (bus.wb_dstE == c_id)) ||
                              ((bus.wb_dstM != RNONE) && (bus.wb_dstM == c_id));

        assign w_inc          = w_accept & w_dst_hit[i];
        assign w_dec          = bus.wb_valid & w_wb_hit[i];
        assign w_busy[i]      = |r_cnt;
        assign w_full[i]      = &r_cnt;
        assign w_underflow[i] = w_dec & ~w_inc & ~|r_cnt;

        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                r_cnt <= '0;
            end else if (bus.flush) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_stall <= '0;
        end else if (bus.issue_valid && !bus.issue_ready && !(&r_stall)) begin
            r_stall <= r_stall + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_err <= 1'b0;
        end else if (!bus.flush && (|w_underflow)) begin
            r_err <= 1'b1;
        end
    end

    assign busy_vec     = w_busy;
    assign stall_cycles = r_stall;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed-vector bench with an expectation queue drained by a
//                negedge monitor.
//  Revision    : 1.0
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk   = 1'b0;
    logic        res_n = 1'b0;
    logic [14:0] busy_vec;
    logic [15:0] stall_cycles;
    logic        err;

    always #5 clk = ~clk;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .clk          (clk),
        .res_n        (res_n),
        .bus          (bus.slave),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles),
        .err          (err)
    );

    localparam int c_f_ready = 0;
    localparam int c_f_busy  = 1;
    localparam int c_f_err   = 2;
    localparam int c_f_stall = 3;

    typedef struct {
        string       name;
        int          cyc;
        int          field;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(input string name, input int d,
                                      input int field, input logic [15:0] val);
        exp_t e;
        e.name  = name;
        e.cyc   = cyc + d;
        e.field = field;
        e.val   = val;
        q.push_back(e);
    endfunction

    // Monitor: pops every expectation due in the current cycle
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [15:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            case (e.field)
                c_f_ready: act = {15'd0, bus.issue_ready};
                c_f_busy:  act = {1'b0, busy_vec};
                c_f_err:   act = {15'd0, err};
                default:   act = stall_cycles;
            endcase
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation missed its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_srcA  = 4'hF;
        bus.issue_srcB  = 4'hF;
        bus.issue_dstE  = 4'hF;
        bus.issue_dstM  = 4'hF;
        bus.wb_valid    = 1'b0;
        bus.wb_dstE     = 4'hF;
        bus.wb_dstM     = 4'hF;
        bus.flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] de, input logic [3:0] dm);
        bus.issue_valid = 1'b1;
        bus.issue_srcA  = sa;
        bus.issue_srcB  = sb;
        bus.issue_dstE  = de;
        bus.issue_dstM  = dm;
    endtask

    task automatic wb(input logic [3:0] de, input logic [3:0] dm);
        bus.wb_valid = 1'b1;
        bus.wb_dstE  = de;
        bus.wb_dstM  = dm;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        expect_at("rst_busy",  0, c_f_busy,  16'h0000);
        expect_at("rst_err",   0, c_f_err,   16'h0000);
        expect_at("rst_stall", 0, c_f_stall, 16'h0000);
        expect_at("rst_ready", 0, c_f_ready, 16'h0001);
        step();
        res_n = 1'b1;

        // irmovq -> rbx, then dependent rrmovq
        step(); issue(4'hF, 4'hF, 4'h3, 4'hF);
        expect_at("irmov_ready", 0, c_f_ready, 16'h0001);
        expect_at("irmov_busy",  1, c_f_busy,  16'h0008);
        step(); issue(4'h3, 4'hF, 4'h7, 4'hF);
        expect_at("raw_stall",   0, c_f_ready, 16'h0000);
        expect_at("stall_cnt1",  1, c_f_stall, 16'h0001);
        step(); issue(4'h3, 4'hF, 4'h7, 4'hF); wb(4'h3, 4'hF);
        expect_at("wb_same_cyc", 0, c_f_ready, 16'h0000);
        expect_at("stall_cnt2",  1, c_f_stall, 16'h0002);
        step(); issue(4'h3, 4'hF, 4'h7, 4'hF);
        expect_at("wb_released", 0, c_f_ready, 16'h0001);
        expect_at("rrmov_busy",  1, c_f_busy,  16'h0080);
        step(); wb(4'h7, 4'hF);
        expect_at("drain7",      1, c_f_busy,  16'h0000);

        // popq %rsp: dstE == dstM counted once
        step(); issue(4'h4, 4'h4, 4'h4, 4'h4);
        expect_at("popq_ready",  0, c_f_ready, 16'h0001);
        expect_at("popq_busy",   1, c_f_busy,  16'h0010);
        step(); wb(4'h4, 4'h4);
        expect_at("popq_wb",     1, c_f_busy,  16'h0000);
        expect_at("popq_err",    1, c_f_err,   16'h0000);

        // simultaneous inc/dec, then underflow
        step(); issue(4'hF, 4'hF, 4'h2, 4'hF);
        expect_at("r2_busy",     1, c_f_busy,  16'h0004);
        step(); issue(4'hF, 4'hF, 4'h2, 4'hF); wb(4'h2, 4'hF);
        expect_at("r2_both_rdy", 0, c_f_ready, 16'h0001);
        expect_at("r2_both",     1, c_f_busy,  16'h0004);
        step(); wb(4'h2, 4'hF);
        expect_at("r2_drain",    1, c_f_busy,  16'h0000);
        step(); wb(4'h2, 4'hF);
        expect_at("underflow",   1, c_f_err,   16'h0001);
        expect_at("uf_busy",     1, c_f_busy,  16'h0000);
        step();
        step();
        expect_at("err_sticky",  1, c_f_err,   16'h0001);

        // saturate counter[5]
        for (int k = 0; k < 3; k++) begin
            step(); issue(4'hF, 4'hF, 4'h5, 4'hF);
            expect_at("r5_fill", 0, c_f_ready, 16'h0001);
        end
        step(); issue(4'hF, 4'hF, 4'h5, 4'hF);
        expect_at("r5_full",     0, c_f_ready, 16'h0000);
        expect_at("r5_busy",     0, c_f_busy,  16'h0020);
        expect_at("stall_cnt3",  1, c_f_stall, 16'h0003);
        step(); issue(4'hF, 4'hF, 4'h5, 4'hF); wb(4'h5, 4'hF);
        expect_at("r5_full_wb",  0, c_f_ready, 16'h0000);
        expect_at("stall_cnt4",  1, c_f_stall, 16'h0004);
        step(); issue(4'hF, 4'hF, 4'h5, 4'hF);
        expect_at("r5_free",     0, c_f_ready, 16'h0001);

        // flush with issue and wb in the same cycle
        step(); issue(4'hF, 4'hF, 4'h6, 4'hF);
        expect_at("r56_busy",    1, c_f_busy,  16'h0060);
        step(); issue(4'hF, 4'hF, 4'h8, 4'hF); wb(4'h5, 4'hF); bus.flush = 1'b1;
        expect_at("flush_rdy",   0, c_f_ready, 16'h0000);
        expect_at("flush_busy",  1, c_f_busy,  16'h0000);
        expect_at("flush_err",   1, c_f_err,   16'h0001);
        expect_at("flush_stall", 1, c_f_stall, 16'h0005);

        // long stall to saturate the statistic, then async reset
        step(); issue(4'hF, 4'hF, 4'h1, 4'hF);
        expect_at("r1_ready",    0, c_f_ready, 16'h0001);
        for (int k = 0; k < 70000; k++) begin
            step(); issue(4'h1, 4'hF, 4'hF, 4'hF);
        end
        step(); issue(4'h1, 4'hF, 4'hF, 4'hF);
        expect_at("stall_sat",   0, c_f_stall, 16'hFFFF);
        expect_at("sat_busy",    0, c_f_busy,  16'h0002);
        expect_at("sat_ready",   0, c_f_ready, 16'h0000);
        step(); issue(4'h1, 4'hF, 4'hF, 4'hF);
        #1 res_n = 1'b0;
        expect_at("arst_busy",   0, c_f_busy,  16'h0000);
        expect_at("arst_stall",  0, c_f_stall, 16'h0000);
        expect_at("arst_err",    0, c_f_err,   16'h0000);
        step();
        res_n = 1'b1;

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
